// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer engine.
//   state_t   : engine FSM states
//   BYTE_BITS : bits in a short (8-bit) transfer
//   WORD_BITS : bits in a long (32-bit) transfer
//   CNT_W     : width of the bit counter
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BYTE_BITS = 8;
   localparam int WORD_BITS = 32;
   localparam int CNT_W     = 5;

endpackage

// File: rtl/spi_clk_div.sv
// SCK generator for the SPI transfer engine.
// Counts CLK_DIV system clocks per SCK half-period while enabled and toggles
// sck at terminal count. rise/fall strobes are high in the cycle whose clock
// edge moves sck 0->1 / 1->0. When disabled the divider and sck sit at zero,
// so every enable starts with a full low half-period.
//   clk, rst_n : system clock, async active-low reset
//   en         : run the divider
//   sck        : SPI clock, idles low
//   sck_rise   : sck goes high at the next clock edge
//   sck_fall   : sck goes low at the next clock edge
module spi_clk_div #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic sck,
   output logic sck_rise,
   output logic sck_fall
);

   localparam int unsigned DIV_W = 8;
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sck_q, sck_d;
   logic             tc;

   always_comb begin
      tc        = en && (div_cnt_q == DIV_TC);
      div_cnt_d = '0;
      sck_d     = 1'b0;
      if (en) begin
         div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
         sck_d     = tc ? ~sck_q : sck_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         sck_q     <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         sck_q     <= sck_d;
      end
   end

   assign sck      = sck_q;
   assign sck_rise = tc & ~sck_q;
   assign sck_fall = tc & sck_q;

endmodule

// File: rtl/spi_xfer_engine.sv
// SPI mode-0 shift engine between the TX and RX FIFOs.
// Pops one command word from a first-word-fall-through TX FIFO, shifts 8 or
// 32 bits MSB first on mosi while capturing miso, then pushes the received
// word (8-bit results zero-extended) into the RX FIFO.
//   clk, rst_n            : system clock, async active-low reset
//   quad                  : 1 = 32-bit transfer, 0 = 8-bit using din[7:0]
//   din/din_valid/din_ready  : TX FIFO head, not-empty, pop strobe
//   dout/dout_valid/dout_ready : received word, push strobe, RX not-full
//   sck, mosi, miso       : SPI pins (sck idles low, mosi idles high)
//   busy                  : engine not idle
//
// state | meaning
// IDLE  | waiting for a TX word; pops it in the same cycle din_valid is seen
// SHIFT | clocking bits out on mosi and in from miso
// DONE  | result held on dout until the RX FIFO can take it
module spi_xfer_engine
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned DW      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          quad,
   input  logic [DW-1:0] din,
   input  logic          din_valid,
   output logic          din_ready,
   output logic [DW-1:0] dout,
   input  logic          dout_ready,
   output logic          dout_valid,
   output logic          sck,
   input  logic          miso,
   output logic          mosi,
   output logic          busy
);

   state_t           state_q, state_d;
   logic             len_q, len_d;
   logic [DW-1:0]    tx_sr_q, tx_sr_d;
   logic [DW-1:0]    rx_sr_q, rx_sr_d;
   logic [DW-1:0]    dout_q, dout_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] last_bit;
   logic             shift_en;
   logic             sck_rise;
   logic             sck_fall;

   assign shift_en = (state_q == SHIFT);
   assign last_bit = len_q ? CNT_W'(WORD_BITS - 1) : CNT_W'(BYTE_BITS - 1);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (shift_en),
      .sck      (sck),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      bit_cnt_d  = bit_cnt_q;
      dout_d     = dout_q;
      din_ready  = 1'b0;
      dout_valid = 1'b0;
      mosi       = 1'b1;
      case (state_q)
         IDLE: begin
            din_ready = din_valid;
            if (din_valid) begin
               len_d     = quad;
               // short transfers are left-justified so bit 31 is always next out
               tx_sr_d   = quad ? din : {din[BYTE_BITS-1:0], {(DW-BYTE_BITS){1'b0}}};
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            mosi = tx_sr_q[DW-1];
            if (sck_rise) begin
               rx_sr_d = {rx_sr_q[DW-2:0], miso};
            end
            if (sck_fall) begin
               tx_sr_d   = tx_sr_q << 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == last_bit) begin
                  // last bit was captured on the preceding rise; rx_sr is complete
                  state_d = DONE;
                  dout_d  = len_q ? rx_sr_q
                                  : {{(DW-BYTE_BITS){1'b0}}, rx_sr_q[BYTE_BITS-1:0]};
               end
            end
         end
         DONE: begin
            if (dout_ready) begin
               dout_valid = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= 1'b0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         dout_q    <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         dout_q    <= dout_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign dout = dout_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed testbench for spi_xfer_engine. Three instances (CLK_DIV = 2, 1, 255)
// share the stimulus; sel picks which one is observed. A negedge monitor counts
// sck edges, pops, pushes and busy cycles and records mosi bits and results.
module tb_spi_xfer_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        quad = 1'b0;
   logic [31:0] din = '0;
   logic        din_valid = 1'b0;
   logic        dout_ready = 1'b1;
   logic        miso;
   logic        loop = 1'b1;
   logic [31:0] slave_sr = '0;
   logic [31:0] slave_pat = '0;
   logic [1:0]  sel = 2'd0;

   logic        dr_w [3];
   logic        dv_w [3];
   logic        sck_w [3];
   logic        mosi_w [3];
   logic        busy_w [3];
   logic [31:0] dout_w [3];

   logic        dr_s, dv_s, sck_s, mosi_s, busy_s;
   logic [31:0] dout_s;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   spi_xfer_engine #(.CLK_DIV(2), .DW(32)) u_d2 (
      .clk(clk), .rst_n(rst_n), .quad(quad), .din(din), .din_valid(din_valid),
      .din_ready(dr_w[0]), .dout(dout_w[0]), .dout_ready(dout_ready),
      .dout_valid(dv_w[0]), .sck(sck_w[0]), .miso(miso), .mosi(mosi_w[0]),
      .busy(busy_w[0]));

   spi_xfer_engine #(.CLK_DIV(1), .DW(32)) u_d1 (
      .clk(clk), .rst_n(rst_n), .quad(quad), .din(din), .din_valid(din_valid),
      .din_ready(dr_w[1]), .dout(dout_w[1]), .dout_ready(dout_ready),
      .dout_valid(dv_w[1]), .sck(sck_w[1]), .miso(miso), .mosi(mosi_w[1]),
      .busy(busy_w[1]));

   spi_xfer_engine #(.CLK_DIV(255), .DW(32)) u_d255 (
      .clk(clk), .rst_n(rst_n), .quad(quad), .din(din), .din_valid(din_valid),
      .din_ready(dr_w[2]), .dout(dout_w[2]), .dout_ready(dout_ready),
      .dout_valid(dv_w[2]), .sck(sck_w[2]), .miso(miso), .mosi(mosi_w[2]),
      .busy(busy_w[2]));

   always_comb begin
      dr_s = dr_w[2]; dv_s = dv_w[2]; sck_s = sck_w[2];
      mosi_s = mosi_w[2]; busy_s = busy_w[2]; dout_s = dout_w[2];
      case (sel)
         2'd0: begin
            dr_s = dr_w[0]; dv_s = dv_w[0]; sck_s = sck_w[0];
            mosi_s = mosi_w[0]; busy_s = busy_w[0]; dout_s = dout_w[0];
         end
         2'd1: begin
            dr_s = dr_w[1]; dv_s = dv_w[1]; sck_s = sck_w[1];
            mosi_s = mosi_w[1]; busy_s = busy_w[1]; dout_s = dout_w[1];
         end
         default: ;
      endcase
   end

   assign miso = loop ? mosi_s : slave_sr[31];

   // monitor
   int          rise_cnt = 0, dv_cnt = 0, pop_cnt = 0, busy_cyc = 0;
   int          gap_cnt = 0, short_gap = 0, low_run = 0, high_run = 0;
   int          last_high = 0, last_low_in = 0;
   logic        sck_p = 1'b0, pend = 1'b0;
   logic [31:0] mosi_word = '0;
   logic [31:0] dout_log [16];
   int          rise_at_dv [16];

   always @(negedge clk) begin
      if (busy_s) busy_cyc++;
      if (dr_s) begin
         pop_cnt++;
         pend = 1'b1;
         slave_sr = slave_pat;
      end
      if (dv_s) begin
         dout_log[dv_cnt % 16]   = dout_s;
         rise_at_dv[dv_cnt % 16] = rise_cnt;
         dv_cnt++;
      end
      if (sck_s) begin
         if (!sck_p) begin
            rise_cnt++;
            mosi_word = {mosi_word[30:0], mosi_s};
            if (pend) begin
               gap_cnt++;
               if (low_run < 2) short_gap++;
               pend = 1'b0;
            end else begin
               last_low_in = low_run;
            end
            high_run = 1;
         end else begin
            high_run++;
         end
      end else begin
         if (sck_p) begin
            last_high = high_run;
            slave_sr  = slave_sr << 1;
            low_run   = 1;
         end else begin
            low_run++;
         end
      end
      sck_p = sck_s;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic [1:0] s);
      rst_n = 1'b0;
      din_valid = 1'b0;
      dout_ready = 1'b1;
      sel = s;
      tick(3);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic push(input string tag, input logic q, input logic [31:0] d);
      int n;
      n = 0;
      quad = q;
      din = d;
      din_valid = 1'b1;
      #1;
      while (!dr_s && n < 50) begin
         tick(1);
         n++;
      end
      check({tag, "_pop"}, {31'd0, dr_s}, 32'd1);
      tick(1);
      din_valid = 1'b0;
   endtask

   task automatic wait_dv(input string tag, input int target, input int max_cyc);
      int n;
      n = 0;
      while (dv_cnt < target && n < max_cyc) begin
         tick(1);
         n++;
      end
      check({tag, "_timeout"}, {31'd0, (dv_cnt >= target)}, 32'd1);
   endtask

   initial begin
      int rise0, dv0, pop0, busy0, gap0, short0, n, bad;
      logic [31:0] ws [3];
      logic        qs [3];

      // reset state
      rst_n = 1'b0;
      tick(3);
      check("rst_sck",  {31'd0, sck_s},  32'd0);
      check("rst_mosi", {31'd0, mosi_s}, 32'd1);
      check("rst_busy", {31'd0, busy_s}, 32'd0);
      check("rst_dr",   {31'd0, dr_s},   32'd0);
      check("rst_dv",   {31'd0, dv_s},   32'd0);
      check("rst_dout", dout_s,          32'd0);
      rst_n = 1'b1;
      tick(2);

      // 8-bit loopback, CLK_DIV=2
      loop = 1'b1;
      rise0 = rise_cnt; dv0 = dv_cnt; pop0 = pop_cnt; busy0 = busy_cyc;
      push("lb8", 1'b0, 32'hDEAD_BEA5);
      check("lb8_busy_now", {31'd0, busy_s}, 32'd1);
      wait_dv("lb8", dv0 + 1, 200);
      tick(3);
      check("lb8_rises",  32'(rise_cnt - rise0), 32'd8);
      check("lb8_mosi",   {24'd0, mosi_word[7:0]}, 32'h0000_00A5);
      check("lb8_dout",   dout_log[dv0 % 16], 32'h0000_00A5);
      check("lb8_dvs",    32'(dv_cnt - dv0), 32'd1);
      check("lb8_pops",   32'(pop_cnt - pop0), 32'd1);
      check("lb8_cycles", 32'(busy_cyc - busy0), 32'd33);
      check("lb8_half",   32'(last_high), 32'd2);
      check("lb8_idle_mosi", {31'd0, mosi_s}, 32'd1);

      // 32-bit transfer against a slave pattern
      loop = 1'b0;
      slave_pat = 32'hCAFE_F00D;
      rise0 = rise_cnt; dv0 = dv_cnt; busy0 = busy_cyc;
      push("w32", 1'b1, 32'h1234_5678);
      wait_dv("w32", dv0 + 1, 400);
      tick(2);
      check("w32_rises",  32'(rise_cnt - rise0), 32'd32);
      check("w32_mosi",   mosi_word, 32'h1234_5678);
      check("w32_dout",   dout_log[dv0 % 16], 32'hCAFE_F00D);
      check("w32_cycles", 32'(busy_cyc - busy0), 32'd129);

      // backpressure
      loop = 1'b1;
      dout_ready = 1'b0;
      dv0 = dv_cnt; pop0 = pop_cnt;
      push("bp", 1'b0, 32'h0000_0096);
      tick(36);
      din = 32'h0000_0069;
      quad = 1'b0;
      din_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (dv_s || dr_s || !busy_s || sck_s || !mosi_s) bad++;
      end
      check("bp_hold",  32'(bad), 32'd0);
      check("bp_nodv",  32'(dv_cnt - dv0), 32'd0);
      check("bp_pops",  32'(pop_cnt - pop0), 32'd1);
      dout_ready = 1'b1;
      #1;
      check("bp_dv",    {31'd0, dv_s}, 32'd1);
      check("bp_dout",  dout_s, 32'h0000_0096);
      tick(1);
      check("bp_next_ready", {31'd0, dr_s}, 32'd1);
      tick(1);
      din_valid = 1'b0;
      check("bp_one_dv", 32'(dv_cnt - dv0), 32'd1);
      check("bp_pops2",  32'(pop_cnt - pop0), 32'd2);
      wait_dv("bp2", dv0 + 2, 200);
      check("bp2_dout", dout_log[(dv0 + 1) % 16], 32'h0000_0069);

      // back-to-back, CLK_DIV=1
      do_reset(2'd1);
      loop = 1'b1;
      ws[0] = 32'hFFFF_FF3C; qs[0] = 1'b0;
      ws[1] = 32'h8001_7EA5; qs[1] = 1'b1;
      ws[2] = 32'h0000_00C3; qs[2] = 1'b0;
      rise0 = rise_cnt; dv0 = dv_cnt; pop0 = pop_cnt; gap0 = gap_cnt; short0 = short_gap;
      din_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         quad = qs[i];
         din = ws[i];
         #1;
         n = 0;
         while (!dr_s && n < 100) begin
            tick(1);
            n++;
         end
         check("b2b_pop", {31'd0, dr_s}, 32'd1);
         tick(1);
      end
      din_valid = 1'b0;
      wait_dv("b2b", dv0 + 3, 200);
      tick(2);
      check("b2b_pops",  32'(pop_cnt - pop0), 32'd3);
      check("b2b_dvs",   32'(dv_cnt - dv0), 32'd3);
      check("b2b_dout0", dout_log[dv0 % 16], 32'h0000_003C);
      check("b2b_dout1", dout_log[(dv0 + 1) % 16], 32'h8001_7EA5);
      check("b2b_dout2", dout_log[(dv0 + 2) % 16], 32'h0000_00C3);
      check("b2b_sck0",  32'(rise_at_dv[dv0 % 16] - rise0), 32'd8);
      check("b2b_sck1",  32'(rise_at_dv[(dv0 + 1) % 16] - rise_at_dv[dv0 % 16]), 32'd32);
      check("b2b_sck2",  32'(rise_at_dv[(dv0 + 2) % 16] - rise_at_dv[(dv0 + 1) % 16]), 32'd8);
      check("b2b_gaps",  32'(gap_cnt - gap0), 32'd3);
      check("b2b_short_gap", 32'(short_gap - short0), 32'd0);

      // async reset mid-SHIFT
      do_reset(2'd0);
      loop = 1'b1;
      rise0 = rise_cnt; dv0 = dv_cnt;
      push("ar", 1'b1, 32'hA5A5_0F0F);
      n = 0;
      while ((rise_cnt - rise0) < 13 && n < 200) begin
         tick(1);
         n++;
      end
      check("ar_reach13", 32'(rise_cnt - rise0), 32'd13);
      rst_n = 1'b0;
      #1;
      check("ar_sck",  {31'd0, sck_s},  32'd0);
      check("ar_mosi", {31'd0, mosi_s}, 32'd1);
      check("ar_busy", {31'd0, busy_s}, 32'd0);
      check("ar_dout", dout_s, 32'd0);
      tick(3);
      rst_n = 1'b1;
      tick(5);
      check("ar_nodv", 32'(dv_cnt - dv0), 32'd0);
      push("ar2", 1'b1, 32'h1357_9BDF);
      wait_dv("ar2", dv0 + 1, 400);
      check("ar2_dout", dout_log[dv0 % 16], 32'h1357_9BDF);

      // CLK_DIV=255, 8-bit
      do_reset(2'd2);
      loop = 1'b1;
      rise0 = rise_cnt; dv0 = dv_cnt; busy0 = busy_cyc;
      push("d255", 1'b0, 32'h0000_005A);
      wait_dv("d255", dv0 + 1, 5000);
      tick(2);
      check("d255_dout",   dout_log[dv0 % 16], 32'h0000_005A);
      check("d255_rises",  32'(rise_cnt - rise0), 32'd8);
      check("d255_high",   32'(last_high), 32'd255);
      check("d255_low",    32'(last_low_in), 32'd255);
      check("d255_cycles", 32'(busy_cyc - busy0), 32'd4081);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired: observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
